// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package adder_sched_pkg;

    // Scheduler phases: operand capture, add, result hand-off.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 10;
    localparam int ID_W      = $clog2(N_REQ_DEF);

endpackage

// File: rtl/adder_rr_scheduler_rca_adder.sv
// Combinational ripple-carry adder, carry-in tied low.
module rca_adder #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    // One full-adder cell per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic p;
        assign p          = a[i] ^ b[i];
        assign sum[i]     = p ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & p);
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one registered adder among N_REQ requesters.
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot on the round-robin winner
// CALC  | latched operands propagating through the adder
// HOLD  | result presented on rsp_*, waiting for rsp_ready
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int RID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic [RID_W-1:0]       rsp_id
);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [RID_W-1:0] rr_ptr;
    logic [RID_W-1:0] grant_idx;
    logic             grant_hit;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [RID_W-1:0] op_id;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rca_adder #(.WIDTH(WIDTH)) u_rca (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int j;
        j         = 0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!grant_hit && req_valid[j]) begin
                grant_hit = 1'b1;
                grant_idx = RID_W'(j);
            end
        end
    end

    // Ready only in IDLE and never while reset is asserted (state is forced to IDLE then).
    assign req_ready = (rst_n && (state_q == IDLE) && grant_hit)
                       ? (N_REQ'(1) << grant_idx) : '0;
    assign accept    = |(req_ready & req_valid);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = HOLD;
            HOLD:    if (rsp_valid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, pointer advance and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                op_a   <= req_a[grant_idx*WIDTH +: WIDTH];
                op_b   <= req_b[grant_idx*WIDTH +: WIDTH];
                op_id  <= grant_idx;
                rr_ptr <= (grant_idx == RID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == CALC) begin
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            // Payload deliberately left in place after the hand-off.
            if ((state_q == HOLD) && rsp_valid && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule
